// File: rtl/sample_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_loader_if
// Brief    : Sample stream, core handshake and read-port bundle for sample_loader.
// Revision : 1.0
// ============================================================================
interface sample_loader_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [DATA_W-1:0] in_y;
    logic              flush;
    logic              core_ready;
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_x;
    logic [DATA_W-1:0] rd_y;
    logic [ADDR_W:0]   fill_count;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, in_x, in_y, flush, core_ready, rd_addr,
        input  in_ready, start, rd_x, rd_y, fill_count, busy, done
    );

    modport slave (
        input  in_valid, in_x, in_y, flush, core_ready, rd_addr,
        output in_ready, start, rd_x, rd_y, fill_count, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : sample_loader
// Brief    : Stages N (x,y) samples, starts the regression core, serves its reads.
// Revision : 1.0
// ============================================================================
module sample_loader #(
    parameter int DATA_W = 20,
    parameter int N      = 150,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    sample_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   c_full_cnt = (ADDR_W + 1)'(N);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W:0]     fill_count_q, fill_count_d;
    logic                start_q,      start_d;
    logic                done_q,       done_d;
    logic                busy_q,       busy_d;
    logic                seen_low_q,   seen_low_d;
    logic [DATA_W-1:0]   rd_x_q,       rd_x_d;
    logic [DATA_W-1:0]   rd_y_q,       rd_y_d;

    logic [2*DATA_W-1:0] mem_q [2**ADDR_W];
    logic [2*DATA_W-1:0] w_rd_word;
    logic                w_in_ready;
    logic                w_wr_en;

    assign w_in_ready = (state_q == S_FILL) && !rst;
    // flush wins over a same-cycle handshake, so the sample never reaches memory
    assign w_wr_en    = w_in_ready && bus.in_valid && !bus.flush;
    assign w_rd_word  = mem_q[bus.rd_addr];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_count_d = fill_count_q;
        seen_low_d   = seen_low_q;
        rd_x_d       = w_rd_word[2*DATA_W-1:DATA_W];
        rd_y_d       = w_rd_word[DATA_W-1:0];

        case (state_q)
            S_FILL: begin
                if (bus.flush) begin
                    wr_ptr_d     = '0;
                    fill_count_d = '0;
                end else if (w_wr_en) begin
                    if (wr_ptr_q == c_last_ptr) begin
                        wr_ptr_d     = '0;
                        fill_count_d = c_full_cnt;
                        state_d      = S_WAIT;
                    end else begin
                        wr_ptr_d     = wr_ptr_q + 1'b1;
                        fill_count_d = fill_count_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.core_ready) state_d = S_START;
            end
            S_START: begin
                seen_low_d = 1'b0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                // The core must be seen leaving idle before its Ready means "finished"
                if (!bus.core_ready)     seen_low_d = 1'b1;
                else if (seen_low_q)     state_d    = S_DONE;
            end
            S_DONE: begin
                fill_count_d = '0;
                state_d      = S_FILL;
            end
            default: state_d = S_FILL;
        endcase

        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d == S_START) || (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            wr_ptr_q     <= '0;
            fill_count_q <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            seen_low_q   <= 1'b0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_count_q <= fill_count_d;
            start_q      <= start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            seen_low_q   <= seen_low_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wr_ptr_q] <= {bus.in_x, bus.in_y};
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.start      = start_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.fill_count = fill_count_q;
    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;
endmodule
`default_nettype wire

// File: doc/sample_loader.md
Name: sample_loader

Overview:
Input staging buffer that sits directly upstream of the regression core. It accepts (x, y) samples over a valid/ready stream and stores N of them in an internal memory. It then pulses Start into the core once the core reports Ready, and serves the core's sample reads during both the accumulation pass and the error pass. When the core returns to Ready, the loader signals completion and re-opens for the next batch.

Parameters:
DATA_W, 20, width of each x and y sample (two's complement)
N, 150, samples per batch (2 <= N <= 2**ADDR_W)
ADDR_W, 8, sample memory address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream sample valid
in_ready  output  1  loader accepts a sample this cycle
in_x  input  DATA_W  sample x
in_y  input  DATA_W  sample y
flush  input  1  discard partially filled batch
core_ready  input  1  Ready from regression core (high in its idle state)
start  output  1  one-cycle Start pulse to core
rd_addr  input  ADDR_W  sample index driven by core's sample counter
rd_x  output  DATA_W  x at rd_addr, registered
rd_y  output  DATA_W  y at rd_addr, registered
fill_count  output  ADDR_W+1  samples stored in current batch
busy  output  1  batch handed to core, not yet finished
done  output  1  one-cycle pulse when core finishes a batch

Behaviour:
- Reset: on clk edge with rst=1, state=FILL, wr_ptr=0, fill_count=0, start=0, done=0, busy=0, rd_x=0, rd_y=0, seen_low=0. Memory contents are not cleared. rst overrides every other input.
- in_ready = (state==FILL) and not rst. It is combinational from state only, with no dependence on in_valid.
- Write: when in_valid & in_ready, mem[wr_ptr] <= {in_x, in_y}, wr_ptr++, fill_count++.
- Read: rd_x/rd_y <= mem[rd_addr] every cycle in every state (1-cycle latency). If rd_addr >= N, the output is don't-care.
- States:
  - FILL: accepts samples. A handshake with wr_ptr==N-1 → WAIT, with wr_ptr wrapping to 0 and fill_count=N.
    - flush=1 in FILL: wr_ptr=0, fill_count=0, and any same-cycle handshake is dropped (flush wins).
  - WAIT: holds the full batch. core_ready=1 → START. flush is ignored.
  - START: start=1 for exactly this cycle, busy=1, seen_low=0 → RUN.
  - RUN: busy=1.
    - core_ready=0 sets seen_low.
    - seen_low=1 and core_ready=1 → DONE.
    - core_ready still 1 with seen_low=0 stays in RUN (tolerates a core that leaves idle late).
    - flush is ignored.
  - DONE: done=1 for this cycle, busy=0, fill_count=0 → FILL.
- start and done are registered (decoded from next state), are never high together, and are never high for two consecutive cycles.
- busy=1 in START and RUN only; 0 in FILL, WAIT, DONE.
- Upstream stalls: in_valid may drop mid-batch; the loader simply waits, with no timeout.
- Memory is not written outside FILL, so the core sees stable data for both of its passes.
- Reset mid-operation (any state): returns to FILL with an empty batch next cycle and start held 0. The core is reset by its own rst.
- Contents of a completed batch remain readable after DONE until overwritten.

Test Plan:
- Basic batch (N=4): rst 1 cycle, then push (1,2),(3,4),(5,6),(7,8) back-to-back.
  - in_ready drops the cycle after the 4th handshake.
  - fill_count=4.
  - With core_ready=1, start pulses exactly 1 cycle, 2 cycles after the last handshake.
- Read port: after filling, drive rd_addr=0,1,2,3 on successive cycles.
  - rd_x/rd_y = (1,2),(3,4),(5,6),(7,8), each one cycle after its address.
- Core handshake (N=4, full): hold core_ready=0 for 5 cycles, then 1.
  - start is asserted only after core_ready rises.
  - core_ready then drops for 20 cycles and returns to 1.
  - done pulses once, busy falls with it, in_ready=1 the next cycle.
- Flush (N=4): push 2 samples, assert flush together with a 3rd valid sample.
  - fill_count=0, that sample is dropped.
  - 4 further pushes are required before start.
- Backpressure in RUN: hold in_valid=1 throughout RUN.
  - in_ready stays 0, no memory writes.
  - Reads of addresses 0..3 are unchanged.
- Reset mid-RUN: assert rst while busy=1.
  - Next cycle state=FILL, busy=0, fill_count=0, start=0, done never pulses.
